// File: rtl/simd_addsub_lanes.sv
// Packed-lane SIMD add/subtract with optional saturation and per-lane overflow flags.
// Two-stage valid/ready pipeline with a global clock enable that freezes all state.
module simd_addsub_lanes #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned W      = 12,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   a_val,
  input  logic [LANES*W-1:0]   b_val,
  input  logic [LANES-1:0]     sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   ap_return,
  output logic [LANES-1:0]     ovf
);

  localparam int unsigned BusW = LANES * W;

  logic                      adv1;
  logic                      adv2;
  logic                      v1_q;
  logic                      v2_q;
  logic [LANES-1:0][W:0]     raw_d;
  logic [LANES-1:0][W:0]     raw_q;
  logic [LANES-1:0]          sub_q;
  logic [BusW-1:0]           res_d;
  logic [BusW-1:0]           res_q;
  logic [LANES-1:0]          ovf_d;
  logic [LANES-1:0]          ovf_q;

  // Flow control: S2 frees when empty or drained; S1 frees when empty or S2 takes it.
  always_comb begin
    adv2 = ap_ce & (~v2_q | out_ready);
    adv1 = ap_ce & (~v1_q | adv2);
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign ap_return = res_q;
  assign ovf       = ovf_q;

  // Stage 1: one extra bit per lane holds carry/borrow (unsigned) or true sign (signed).
  always_comb begin
    logic [W-1:0] a_l;
    logic [W-1:0] b_l;
    logic [W:0]   ea;
    logic [W:0]   eb;
    raw_d = '0;
    a_l   = '0;
    b_l   = '0;
    ea    = '0;
    eb    = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      a_l = a_val[i*W +: W];
      b_l = b_val[i*W +: W];
      if (SIGNED) begin
        ea = {a_l[W-1], a_l};
        eb = {b_l[W-1], b_l};
      end else begin
        ea = {1'b0, a_l};
        eb = {1'b0, b_l};
      end
      raw_d[i] = sub[i] ? (ea - eb) : (ea + eb);
    end
  end

  // Stage 2: overflow detection and optional clamp, lane by lane.
  always_comb begin
    logic [W:0]   r;
    logic         of;
    logic [W-1:0] sat_val;
    res_d   = '0;
    ovf_d   = '0;
    r       = '0;
    of      = 1'b0;
    sat_val = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      r = raw_q[i];
      if (SIGNED) begin
        // Sign-extended result disagrees with its truncation exactly on overflow.
        of      = r[W] ^ r[W-1];
        sat_val = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        of      = r[W];
        sat_val = sub_q[i] ? {W{1'b0}} : {W{1'b1}};
      end
      ovf_d[i]          = of;
      res_d[i*W +: W]   = (SAT && of) ? sat_val : r[W-1:0];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v1_q  <= 1'b0;
      raw_q <= '0;
      sub_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        raw_q <= raw_d;
        sub_q <= sub;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v2_q  <= 1'b0;
      res_q <= '0;
      ovf_q <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_simd_addsub_lanes.sv
// Directed bench for simd_addsub_lanes: four arithmetic variants on shared stimulus,
// plus backpressure, clock-enable freeze and asynchronous reset flow checks.
module tb_simd_addsub_lanes;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_ce;
  logic        in_valid;
  logic [47:0] a_val;
  logic [47:0] b_val;
  logic [3:0]  sub;
  logic        out_ready;

  logic        rdy_us, rdy_uss, rdy_sw, rdy_ss;
  logic        ov_us, ov_uss, ov_sw, ov_ss;
  logic [47:0] ret_us, ret_uss, ret_sw, ret_ss;
  logic [3:0]  ovf_us, ovf_uss, ovf_sw, ovf_ss;

  int n_cmp = 0;
  int n_err = 0;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  simd_addsub_lanes #(.LANES(4), .W(12), .SIGNED(1'b0), .SAT(1'b0)) u_us (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .in_valid(in_valid), .in_ready(rdy_us),
    .a_val(a_val), .b_val(b_val), .sub(sub), .out_valid(ov_us), .out_ready(out_ready),
    .ap_return(ret_us), .ovf(ovf_us));

  simd_addsub_lanes #(.LANES(4), .W(12), .SIGNED(1'b0), .SAT(1'b1)) u_uss (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .in_valid(in_valid), .in_ready(rdy_uss),
    .a_val(a_val), .b_val(b_val), .sub(sub), .out_valid(ov_uss), .out_ready(out_ready),
    .ap_return(ret_uss), .ovf(ovf_uss));

  simd_addsub_lanes #(.LANES(4), .W(12), .SIGNED(1'b1), .SAT(1'b0)) u_sw (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .in_valid(in_valid), .in_ready(rdy_sw),
    .a_val(a_val), .b_val(b_val), .sub(sub), .out_valid(ov_sw), .out_ready(out_ready),
    .ap_return(ret_sw), .ovf(ovf_sw));

  simd_addsub_lanes #(.LANES(4), .W(12), .SIGNED(1'b1), .SAT(1'b1)) u_ss (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .in_valid(in_valid), .in_ready(rdy_ss),
    .a_val(a_val), .b_val(b_val), .sub(sub), .out_valid(ov_ss), .out_ready(out_ready),
    .ap_return(ret_ss), .ovf(ovf_ss));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Streaming operands: lane i of beat k carries k*16+i; B adds 0x100 to every lane.
  function automatic logic [47:0] beat_a(input int k);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*12 +: 12] = 12'(k * 16 + i);
    return r;
  endfunction

  function automatic logic [47:0] beat_exp(input int k);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*12 +: 12] = 12'(k * 16 + i + 256);
    return r;
  endfunction

  localparam logic [47:0] BeatB = 48'h100_100_100_100;

  // Presents one beat on an idle pipeline; returns when it is on ap_return.
  task automatic run_beat(input logic [47:0] a, input logic [47:0] b, input logic [3:0] s);
    ap_ce = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a_val = a; b_val = b; sub = s;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, rcvd, last_c, vcount;
    logic [47:0] held;

    ap_rst = 1'b1; ap_ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_val = '0; b_val = '0; sub = '0;
    #12;
    check_eq("reset out_valid", 64'(ov_us), 64'd0);
    check_eq("reset ap_return", 64'(ret_us), 64'd0);
    check_eq("reset ovf", 64'(ovf_us), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #1;
    check_eq("idle in_ready", 64'(rdy_us), 64'd1);

    // Signed overflow, lane 0: 0x7FF + 0x001.
    run_beat(48'h000_000_000_7FF, 48'h000_000_000_001, 4'b0000);
    check_eq("lat2 out_valid", 64'(ov_sw), 64'd1);
    check_eq("s wrap ret", 64'(ret_sw), 64'h000_000_000_800);
    check_eq("s wrap ovf", 64'(ovf_sw), 64'b0001);
    check_eq("s sat ret", 64'(ret_ss), 64'h000_000_000_7FF);
    check_eq("s sat ovf", 64'(ovf_ss), 64'b0001);
    check_eq("u no-ovf ret", 64'(ret_us), 64'h000_000_000_800);
    check_eq("u no-ovf ovf", 64'(ovf_us), 64'b0000);

    // Unsigned borrow, lane 2: 0x005 - 0x00A.
    run_beat(48'h000_005_000_000, 48'h000_00A_000_000, 4'b0100);
    check_eq("u sat sub ret", 64'(ret_uss), 64'h000_000_000_000);
    check_eq("u sat sub ovf", 64'(ovf_uss), 64'b0100);
    check_eq("u wrap sub ret", 64'(ret_us), 64'h000_FFB_000_000);
    check_eq("u wrap sub ovf", 64'(ovf_us), 64'b0100);
    check_eq("s sub no-ovf ret", 64'(ret_sw), 64'h000_FFB_000_000);
    check_eq("s sub no-ovf ovf", 64'(ovf_sw), 64'b0000);

    // Lane isolation: carry out of lane 0 must not reach lane 1.
    run_beat(48'h000_000_123_FFF, 48'h000_000_000_001, 4'b0000);
    check_eq("iso u ret", 64'(ret_us), 64'h000_000_123_000);
    check_eq("iso u ovf", 64'(ovf_us), 64'b0001);
    check_eq("iso u sat ret", 64'(ret_uss), 64'h000_000_123_FFF);
    check_eq("iso s ovf", 64'(ovf_sw), 64'b0000);

    // Signed negative overflow, lane 3: 0x800 - 0x001.
    run_beat(48'h800_000_000_000, 48'h001_000_000_000, 4'b1000);
    check_eq("s neg wrap ret", 64'(ret_sw), 64'h7FF_000_000_000);
    check_eq("s neg wrap ovf", 64'(ovf_sw), 64'b1000);
    check_eq("s neg sat ret", 64'(ret_ss), 64'h800_000_000_000);
    check_eq("u no-borrow ovf", 64'(ovf_us), 64'b0000);

    // Drain the last beat.
    @(posedge ap_clk); #1;
    check_eq("drained out_valid", 64'(ov_us), 64'd0);

    // Backpressure: 6 beats, consumer stalled for the first 5 cycles.
    sent = 0; rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      ap_ce = 1'b1;
      in_valid = (sent < 6);
      a_val = beat_a(sent); b_val = BeatB; sub = '0;
      out_ready = (c >= 5);
      #1;
      if (c == 2) check_eq("bp in_ready full", 64'(rdy_us), 64'd0);
      if (c == 4) check_eq("bp held beats", 64'(sent), 64'd2);
      if (in_valid && rdy_us) sent++;
      if (ov_us && out_ready) begin
        check_eq($sformatf("bp beat%0d ret", rcvd), 64'(ret_us), 64'(beat_exp(rcvd)));
        rcvd++;
      end
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp beats out", 64'(rcvd), 64'd6);

    // Clock-enable freeze for 3 cycles mid-stream with consumer ready.
    @(posedge ap_clk); #1;
    sent = 0; rcvd = 0; last_c = -1; held = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      ap_ce = !(c >= 3 && c <= 5);
      in_valid = (sent < 8);
      a_val = beat_a(sent + 10); b_val = BeatB; sub = '0;
      out_ready = 1'b1;
      #1;
      if (c == 3) held = ret_us;
      if (c == 4 || c == 5) begin
        check_eq($sformatf("ce freeze c%0d ret", c), 64'(ret_us), 64'(held));
        check_eq($sformatf("ce freeze c%0d in_ready", c), 64'(rdy_us), 64'd0);
        check_eq($sformatf("ce freeze c%0d out_valid", c), 64'(ov_us), 64'd1);
      end
      if (ap_ce && in_valid && rdy_us) sent++;
      if (ap_ce && ov_us && out_ready) begin
        check_eq($sformatf("ce beat%0d ret", rcvd), 64'(ret_us), 64'(beat_exp(rcvd + 10)));
        rcvd++;
        last_c = c;
      end
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0; ap_ce = 1'b1;
    check_eq("ce beats out", 64'(rcvd), 64'd8);
    check_eq("ce last beat cycle", 64'(last_c), 64'd12);

    // Asynchronous reset between edges with both stages holding beats.
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a_val = 48'h000_000_123_FFF; b_val = 48'h000_000_000_001; sub = '0;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    check_eq("pre-rst out_valid", 64'(ov_us), 64'd1);
    check_eq("pre-rst ret", 64'(ret_us), 64'h000_000_123_000);
    #2;
    ap_rst = 1'b1;
    #1;
    check_eq("async rst out_valid", 64'(ov_us), 64'd0);
    check_eq("async rst ret", 64'(ret_us), 64'd0);
    check_eq("async rst ovf", 64'(ovf_us), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0; out_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ov_us) vcount++;
      @(posedge ap_clk); #1;
    end
    check_eq("post-rst no beats", 64'(vcount), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
